// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - shared flag indices, ALU opcodes and buffer state type
package alu_result_stage_pkg;

    localparam int DEF_WIDTH = 8;

    // Status flag bit positions within {V,C,N,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // ALU opcodes shared with the ALU and the control unit
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_INCB = 3'b110;
    localparam logic [2:0] OP_NEGB = 3'b111;

    typedef logic [3:0] flags_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - ALU-side push and write-back-side pop handshake bundle
interface alu_result_stage_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] res_in;
    logic         cout_in;
    logic [2:0]   selop_in;
    logic         a_msb;
    logic         b_msb;
    logic         flags_we;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_res;
    logic [3:0]   out_flags;

    // master: the surrounding datapath (ALU producer + write-back consumer)
    modport master (
        output in_valid, res_in, cout_in, selop_in, a_msb, b_msb, flags_we, out_ready,
        input  in_ready, out_valid, out_res, out_flags
    );

    // slave: the result stage itself
    modport slave (
        input  in_valid, res_in, cout_in, selop_in, a_msb, b_msb, flags_we, out_ready,
        output in_ready, out_valid, out_res, out_flags
    );
endinterface

// File: rtl/alu_result_stage_flag_gen.sv
// rtl/alu_result_stage_flag_gen.sv - combinational Z/N/C/V derivation from an ALU result
module alu_flag_gen
    import alu_result_stage_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  logic [N-1:0] res,
    input  logic         cout,
    input  logic [2:0]   selop,
    input  logic         a_msb,
    input  logic         b_msb,
    output flags_t       flags
);

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_N] = res[N-1];
        flags[FLAG_C] = cout;
        // Overflow only exists for the signed-arithmetic opcodes
        case (selop)
            OP_ADD:  flags[FLAG_V] = (a_msb == b_msb) & (res[N-1] != a_msb);
            OP_INCB: flags[FLAG_V] = ~b_msb & res[N-1];
            OP_NEGB: flags[FLAG_V] = b_msb & res[N-1];
            default: flags[FLAG_V] = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result capture: flag derivation, 2-entry skid buffer, status register
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_stage_if.slave   bus,
    input  logic                clear_flags,
    output flags_t              status_flags
);

    buf_state_t   state;
    buf_state_t   state_nxt;
    logic         push;
    logic         pop;
    logic         wr_head;
    flags_t       new_flags;
    logic [N-1:0] ent0_res;
    logic [N-1:0] ent1_res;
    flags_t       ent0_flags;
    flags_t       ent1_flags;

    alu_flag_gen #(.N(N)) u_flag_gen (
        .res   (bus.res_in),
        .cout  (bus.cout_in),
        .selop (bus.selop_in),
        .a_msb (bus.a_msb),
        .b_msb (bus.b_msb),
        .flags (new_flags)
    );

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (push) state_nxt = ST_ONE;
            ST_ONE: begin
                if (push && !pop)      state_nxt = ST_FULL;
                else if (pop && !push) state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (pop) state_nxt = ST_ONE;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Handshake outputs depend on registered state only
    always_comb begin
        bus.in_ready  = 1'b1;
        bus.out_valid = 1'b0;
        case (state)
            ST_EMPTY: begin
                bus.in_ready  = 1'b1;
                bus.out_valid = 1'b0;
            end
            ST_ONE: begin
                bus.in_ready  = 1'b1;
                bus.out_valid = 1'b1;
            end
            ST_FULL: begin
                bus.in_ready  = 1'b0;
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.in_ready  = 1'b1;
                bus.out_valid = 1'b0;
            end
        endcase
    end

    // New entry lands at the head when the buffer is empty or its only entry leaves now
    assign wr_head = (state == ST_EMPTY) | ((state == ST_ONE) & pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_res   <= '0;
            ent0_flags <= '0;
            ent1_res   <= '0;
            ent1_flags <= '0;
        end else begin
            if ((state == ST_FULL) && pop) begin
                ent0_res   <= ent1_res;
                ent0_flags <= ent1_flags;
            end
            if (push) begin
                if (wr_head) begin
                    ent0_res   <= bus.res_in;
                    ent0_flags <= new_flags;
                end else begin
                    ent1_res   <= bus.res_in;
                    ent1_flags <= new_flags;
                end
            end
        end
    end

    assign bus.out_res   = ent0_res;
    assign bus.out_flags = ent0_flags;

    // Architectural status tracks accepted results, not the drain side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_flags <= '0;
        end else if (clear_flags) begin
            status_flags <= '0;
        end else if (push && bus.flags_we) begin
            status_flags <= new_flags;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed bench with queue-based reference model for alu_result_stage
module tb_alu_result_stage;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flags;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_flags;
    logic [3:0] status_flags;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ent_t       mq[$];
    logic [3:0] m_status;
    logic [7:0] log_res[$];
    int         log_cyc[$];

    always #5 clk = ~clk;

    alu_result_stage_if #(.N(8)) bus ();

    alu_result_stage #(.N(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clear_flags  (clear_flags),
        .status_flags (status_flags)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flags straight from the arithmetic meaning of each opcode
    function automatic logic [3:0] model_flags(input logic [7:0] r, input logic c,
                                               input logic [2:0] s, input logic a, input logic b);
        logic v;
        case (s)
            3'b101:  v = (a == b) && (r[7] != a);
            3'b110:  v = !b && r[7];
            3'b111:  v = b && r[7];
            default: v = 1'b0;
        endcase
        return {v, c, r[7], (r == 8'h00)};
    endfunction

    // Reference model: FIFO of at most two entries plus a status word
    initial begin
        forever begin
            ent_t e;
            bit   do_push;
            bit   do_pop;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_status = 4'h0;
            end else begin
                cyc++;
                do_push = bus.in_valid && (mq.size() < 2);
                do_pop  = (mq.size() > 0) && bus.out_ready;
                e.res   = bus.res_in;
                e.flags = model_flags(bus.res_in, bus.cout_in, bus.selop_in, bus.a_msb, bus.b_msb);
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(e);
                if (clear_flags) m_status = 4'h0;
                else if (do_push && bus.flags_we) m_status = e.flags;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != 2));
            chk("status_flags", 32'(status_flags), 32'(m_status));
            if (mq.size() != 0) begin
                chk("out_res", 32'(bus.out_res), 32'(mq[0].res));
                chk("out_flags", 32'(bus.out_flags), 32'(mq[0].flags));
            end
            if (rst_n && bus.out_valid && bus.out_ready) begin
                log_res.push_back(bus.out_res);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] r, input logic c, input logic [2:0] s,
                         input logic a, input logic b, input logic we, input logic clr,
                         input logic ordy);
        bus.in_valid  = v;
        bus.res_in    = r;
        bus.cout_in   = c;
        bus.selop_in  = s;
        bus.a_msb     = a;
        bus.b_msb     = b;
        bus.flags_we  = we;
        clear_flags   = clr;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        @(negedge clk);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst status", 32'(status_flags), 32'h0);
        chk("rst out_res", 32'(bus.out_res), 32'h00);
        chk("rst out_flags", 32'(bus.out_flags), 32'h0);
        tick();

        // ADD with signed overflow and zero result
        drive(1, 8'h00, 1, 3'b101, 1, 1, 1, 0, 1);
        tick();
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("add out_valid", 32'(bus.out_valid), 32'd1);
        chk("add out_res", 32'(bus.out_res), 32'h00);
        chk("add out_flags", 32'(bus.out_flags), 32'hD);
        chk("add status", 32'(status_flags), 32'hD);
        tick();
        tick();

        // Backpressure: two accepted, third held off until space frees up
        log_res.delete();
        log_cyc.delete();
        drive(1, 8'h11, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8'h22, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8'h33, 0, 3'b000, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp head", 32'(bus.out_res), 32'h11);
        tick();
        tick();
        bus.out_ready = 1'b1;
        tick();
        tick();
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 1);
        tick();
        tick();
        chk("bp count", 32'(log_res.size()), 32'd3);
        if (log_res.size() == 3) begin
            chk("bp order0", 32'(log_res[0]), 32'h11);
            chk("bp order1", 32'(log_res[1]), 32'h22);
            chk("bp order2", 32'(log_res[2]), 32'h33);
        end

        // Streaming at one result per cycle
        log_res.delete();
        log_cyc.delete();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 8'(i), 0, 3'b000, 0, 0, 0, 0, 1);
            tick();
        end
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 1);
        tick();
        tick();
        chk("stream count", 32'(log_res.size()), 32'd8);
        if (log_res.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("stream data", 32'(log_res[i]), 32'(i + 1));
                chk("stream cycle", 32'(log_cyc[i] - log_cyc[0]), 32'(i));
            end
        end

        // NEG of the most negative value, then a flag-less AND result
        drive(1, 8'h80, 0, 3'b111, 0, 1, 1, 0, 1);
        tick();
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("neg out_res", 32'(bus.out_res), 32'h80);
        chk("neg out_flags", 32'(bus.out_flags), 32'hA);
        chk("neg status", 32'(status_flags), 32'hA);
        tick();
        drive(1, 8'h00, 0, 3'b000, 0, 0, 0, 0, 1);
        tick();
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("and out_flags", 32'(bus.out_flags), 32'h1);
        chk("and status", 32'(status_flags), 32'hA);
        tick();

        // Clear wins over a same-cycle update
        drive(1, 8'h80, 0, 3'b111, 0, 1, 1, 1, 1);
        tick();
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("clr out_flags", 32'(bus.out_flags), 32'hA);
        chk("clr status", 32'(status_flags), 32'h0);
        tick();

        // INCB overflow 0x7F+1
        drive(1, 8'h80, 0, 3'b110, 0, 0, 1, 0, 1);
        tick();
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("incb out_flags", 32'(bus.out_flags), 32'hA);
        tick();

        // Asynchronous reset while full and stalled
        drive(1, 8'h80, 0, 3'b101, 0, 0, 1, 0, 0);
        tick();
        drive(1, 8'h44, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full in_ready", 32'(bus.in_ready), 32'd0);
        chk("full status", 32'(status_flags), 32'hA);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst status", 32'(status_flags), 32'h0);
        chk("arst out_res", 32'(bus.out_res), 32'h00);
        chk("arst out_flags", 32'(bus.out_flags), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        drive(1, 8'h5A, 0, 3'b000, 0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 0, 3'b000, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post-rst head", 32'(bus.out_res), 32'h5A);
        chk("post-rst valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("post-rst alone", 32'(bus.out_valid), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
